intersection_phase_scheduler: RTL and testbench



---
 rtl/intersection_phase_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/intersection_phase_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_phase_scheduler
//
// Timed phase sequencer for a two-road intersection (roads A and B).
// Sequence: GA -> YA -> RED1 -> GB -> YB -> RED2 -> GA.
// Green phases have a minimum and a maximum duration. Yellow and all-red
// clearance intervals have fixed durations. Pedestrian buttons are latched and
// served as a walk signal for the whole of the matching green. All timing is
// counted in ticks from an external prescaler enable.
//
// Optional feature (compile-time macro EMERGENCY_PREEMPT_EN):
//   Adds the preempt and preempt_b inputs. While preempt is high, the green of
//   the road selected by preempt_b is forced and held. Clearance timing is
//   still honoured, and walk outputs are suppressed.
//
// Ports:
//   clk         in   clock
//   rst         in   asynchronous, active-high reset
//   tick        in   one-cycle timing enable; timers advance only when high
//   ta, tb      in   vehicle present on road A / road B
//   ped_a_req   in   pedestrian button, crossing with road A flow
//   ped_b_req   in   pedestrian button, crossing with road B flow
//   preempt     in   (EMERGENCY_PREEMPT_EN only) emergency preemption request
//   preempt_b   in   (EMERGENCY_PREEMPT_EN only) 1: target road B, 0: road A
//   ra, ya, ga  out  road A lamps
//   rb, yb, gb  out  road B lamps
//   walk_a      out  walk signal, crossing with road A flow
//   walk_b      out  walk signal, crossing with road B flow
//   phase       out  current state code (GA=0 .. RED2=5)
// -----------------------------------------------------------------------------
module intersection_phase_scheduler #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW    = 2,
  parameter int ALL_RED   = 1,
  parameter int CW        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ta,
  input  logic       tb,
  input  logic       ped_a_req,
  input  logic       ped_b_req,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic       preempt,
  input  logic       preempt_b,
`endif
  output logic       ra,
  output logic       ya,
  output logic       ga,
  output logic       rb,
  output logic       yb,
  output logic       gb,
  output logic       walk_a,
  output logic       walk_b,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_GA   = 3'd0,
    S_YA   = 3'd1,
    S_RED1 = 3'd2,
    S_GB   = 3'd3,
    S_YB   = 3'd4,
    S_RED2 = 3'd5
  } state_t;

  localparam logic [CW-1:0] MIN_G_M1  = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_G_M1  = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] YEL_M1    = CW'(YELLOW - 1);
  localparam logic [CW-1:0] ALLRED_M1 = CW'(ALL_RED - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ped_a_pend, ped_b_pend;
  logic          walk_a_q, walk_b_q;
  logic          demand_a, demand_b;
  logic          enter_ga, leave_ga, enter_gb, leave_gb;

  // Preemption qualifiers. These are constant zero when the feature is
  // compiled out, so the base sequencing below is untouched.
  logic          pre_any, pre_to_a, pre_to_b;
`ifdef EMERGENCY_PREEMPT_EN
  assign pre_any  = preempt;
  assign pre_to_a = preempt & ~preempt_b;
  assign pre_to_b = preempt &  preempt_b;
`else
  assign pre_any  = 1'b0;
  assign pre_to_a = 1'b0;
  assign pre_to_b = 1'b0;
`endif

  assign demand_a = ta | ped_a_pend;
  assign demand_b = tb | ped_b_pend;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_GA: begin
        // Preemption toward B cuts the green short and ignores MIN_GREEN.
        // Preemption toward A freezes this green regardless of demand.
        if (tick && (pre_to_b ||
                     (!pre_to_a && cnt_q >= MIN_G_M1 && demand_b &&
                      (!ta || cnt_q == MAX_G_M1))))
          state_d = S_YA;
      end
      S_YA:   if (tick && cnt_q == YEL_M1)    state_d = S_RED1;
      S_RED1: if (tick && cnt_q == ALLRED_M1) state_d = S_GB;
      S_GB: begin
        if (tick && (pre_to_a ||
                     (!pre_to_b && cnt_q >= MIN_G_M1 && demand_a &&
                      (!tb || cnt_q == MAX_G_M1))))
          state_d = S_YB;
      end
      S_YB:   if (tick && cnt_q == YEL_M1)    state_d = S_RED2;
      S_RED2: if (tick && cnt_q == ALLRED_M1) state_d = S_GA;
      // Codes 6 and 7 recover to GA on the next cycle without waiting for tick.
      default: state_d = S_GA;
    endcase
  end

  // Phase timer: cleared on any state change, otherwise counts ticks and
  // saturates so a long-resting green never wraps back below MIN_GREEN.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = '0;
    else if (tick && cnt_q != MAX_G_M1)
      cnt_d = cnt_q + 1'b1;
  end

  assign enter_ga = (state_d == S_GA) && (state_q != S_GA);
  assign leave_ga = (state_q == S_GA) && (state_d != S_GA);
  assign enter_gb = (state_d == S_GB) && (state_q != S_GB);
  assign leave_gb = (state_q == S_GB) && (state_d != S_GB);

  // ---------------------------------------------------------------------------
  // State, timer, pedestrian registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_GA;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // On entry to a green the pending request (or a request arriving in the
  // very same cycle) becomes the walk for that whole green. Under preemption
  // no walk is granted and the request stays pending for a later green.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ped_a_pend <= 1'b0;
      walk_a_q   <= 1'b0;
    end else if (enter_ga) begin
      walk_a_q   <= (ped_a_pend | ped_a_req) & ~pre_any;
      ped_a_pend <= pre_any & (ped_a_pend | ped_a_req);
    end else if (leave_ga) begin
      walk_a_q   <= 1'b0;
    end else if (state_q != S_GA && ped_a_req) begin
      ped_a_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ped_b_pend <= 1'b0;
      walk_b_q   <= 1'b0;
    end else if (enter_gb) begin
      walk_b_q   <= (ped_b_pend | ped_b_req) & ~pre_any;
      ped_b_pend <= pre_any & (ped_b_pend | ped_b_req);
    end else if (leave_gb) begin
      walk_b_q   <= 1'b0;
    end else if (state_q != S_GB && ped_b_req) begin
      ped_b_pend <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Red is the default on both roads, so illegal codes still show exactly one
  // lamp per road.
  always_comb begin
    ra = 1'b1;
    ya = 1'b0;
    ga = 1'b0;
    rb = 1'b1;
    yb = 1'b0;
    gb = 1'b0;
    case (state_q)
      S_GA: begin ra = 1'b0; ga = 1'b1; end
      S_YA: begin ra = 1'b0; ya = 1'b1; end
      S_GB: begin rb = 1'b0; gb = 1'b1; end
      S_YB: begin rb = 1'b0; yb = 1'b1; end
      default: ;
    endcase
  end

  assign walk_a = walk_a_q & ~pre_any;
  assign walk_b = walk_b_q & ~pre_any;
  assign phase  = state_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tb_intersection_phase_scheduler
//
// Scoreboard bench. The driver applies inputs on the falling edge. After each
// rising edge it advances a behavioural model and pushes the expected outputs
// into a queue. A separate monitor samples the DUT shortly after every rising
// edge, pops one expectation and compares.
//
// The model tracks the phase as an index into the cyclic phase list, keeps an
// unbounded count of ticks spent in the current phase, and keeps pedestrian
// flags as plain bits.
// -----------------------------------------------------------------------------
module tb_intersection_phase_scheduler;

  localparam int MIN_GREEN = 4;
  localparam int MAX_GREEN = 12;
  localparam int YELLOW    = 2;
  localparam int ALL_RED   = 1;
  localparam int CW        = 4;

  logic       clk = 1'b0;
  logic       rst, tick, ta, tb, ped_a_req, ped_b_req;
  logic       preempt, preempt_b;
  logic       ra, ya, ga, rb, yb, gb, walk_a, walk_b;
  logic [2:0] phase;

  always #5 clk = ~clk;

  intersection_phase_scheduler #(
    .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN), .YELLOW(YELLOW),
    .ALL_RED(ALL_RED), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .ta(ta), .tb(tb),
    .ped_a_req(ped_a_req), .ped_b_req(ped_b_req),
`ifdef EMERGENCY_PREEMPT_EN
    .preempt(preempt), .preempt_b(preempt_b),
`endif
    .ra(ra), .ya(ya), .ga(ga), .rb(rb), .yb(yb), .gb(gb),
    .walk_a(walk_a), .walk_b(walk_b), .phase(phase)
  );

  typedef struct packed {
    logic [2:0] phase;
    logic [5:0] lamps;  // {ra, ya, ga, rb, yb, gb}
    logic       wa;
    logic       wb;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Lamp pattern per phase, in {ra,ya,ga,rb,yb,gb} order:
  // GA, YA, RED1, GB, YB, RED2.
  logic [5:0] lamp_tab [6] = '{6'b001_100, 6'b010_100, 6'b100_100,
                               6'b100_001, 6'b100_010, 6'b100_100};

  // Behavioural model state.
  int m_ph;  // 0..5 index into the phase cycle
  int m_el;  // ticks already spent in the current phase
  bit m_pa, m_pb, m_wa, m_wb;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_el = 0; m_pa = 0; m_pb = 0; m_wa = 0; m_wb = 0;
  endtask

  // Advance the model by one clock, using the inputs held during that cycle.
  task automatic model_step(input bit r, input bit tk, input bit a, input bit b,
                            input bit pa, input bit pb);
    int nxt;
    int done;
    if (r) begin
      model_reset();
      return;
    end
    nxt  = m_ph;
    done = m_el + 1;  // ticks completed in this phase if this cycle ticks
    if (tk) begin
      case (m_ph)
        0: if (done >= MIN_GREEN && (b || m_pb) && (!a || done >= MAX_GREEN)) nxt = 1;
        3: if (done >= MIN_GREEN && (a || m_pa) && (!b || done >= MAX_GREEN)) nxt = 4;
        1, 4: if (done == YELLOW)  nxt = (m_ph + 1) % 6;
        default: if (done == ALL_RED) nxt = (m_ph + 1) % 6;
      endcase
    end
    // Road A pedestrian bookkeeping.
    if (nxt == 0 && m_ph != 0) begin
      m_wa = m_pa | pa; m_pa = 0;
    end else if (m_ph == 0 && nxt != 0) begin
      m_wa = 0;
    end else if (m_ph != 0 && pa) begin
      m_pa = 1;
    end
    // Road B pedestrian bookkeeping.
    if (nxt == 3 && m_ph != 3) begin
      m_wb = m_pb | pb; m_pb = 0;
    end else if (m_ph == 3 && nxt != 3) begin
      m_wb = 0;
    end else if (m_ph != 3 && pb) begin
      m_pb = 1;
    end
    if (nxt != m_ph) m_el = 0;
    else if (tk)     m_el = m_el + 1;
    m_ph = nxt;
  endtask

  // One clock of stimulus; the expectation is queued after the rising edge.
  task automatic cycle(input bit r, input bit tk, input bit a, input bit b,
                       input bit pa, input bit pb);
    exp_t e;
    @(negedge clk);
    rst = r; tick = tk; ta = a; tb = b; ped_a_req = pa; ped_b_req = pb;
    @(posedge clk);
    model_step(r, tk, a, b, pa, pb);
    e.phase = 3'(m_ph);
    e.lamps = lamp_tab[m_ph];
    e.wa    = m_wa;
    e.wb    = m_wb;
    q.push_back(e);
  endtask

  // Monitor: compares every presented cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        check("phase",  32'(phase), 32'(e.phase));
        check("lamps",  32'({ra, ya, ga, rb, yb, gb}), 32'(e.lamps));
        check("walk_a", 32'(walk_a), 32'(e.wa));
        check("walk_b", 32'(walk_b), 32'(e.wb));
        check("one_lamp_a", 32'(ra + ya + ga), 32'd1);
        check("one_lamp_b", 32'(rb + yb + gb), 32'd1);
      end
    end
  end

  initial begin
    bit sa, sb;
    int guard;
    rst = 1'b1; tick = 1'b0; ta = 1'b0; tb = 1'b0;
    ped_a_req = 1'b0; ped_b_req = 1'b0;
    preempt = 1'b0; preempt_b = 1'b0;
    model_reset();

    // Idle: ticking, no demand -> GA rests.
    cycle(1, 0, 0, 0, 0, 0);
    repeat (50) cycle(0, 1, 0, 0, 0, 0);

    // Demand only on B: A to B handover, then GB rests.
    cycle(1, 0, 0, 0, 0, 0);
    repeat (25) cycle(0, 1, 0, 1, 0, 0);

    // Demand on both roads: full max-green cycle, twice round.
    cycle(1, 0, 0, 0, 0, 0);
    repeat (70) cycle(0, 1, 1, 1, 0, 0);

    // Single pedestrian press for B with no vehicles.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 1);
    repeat (20) cycle(0, 1, 0, 0, 0, 0);

    // Ticks withheld: everything frozen.
    cycle(1, 0, 0, 0, 0, 0);
    repeat (2)  cycle(0, 1, 0, 1, 0, 0);
    repeat (20) cycle(0, 0, 0, 1, 0, 0);
    repeat (5)  cycle(0, 1, 0, 1, 0, 0);

    // Reset while in YB.
    cycle(1, 0, 0, 0, 0, 0);
    guard = 0;
    while (m_ph != 4 && guard < 100) begin
      cycle(0, 1, 1, 1, 0, 0);
      guard++;
    end
    check("reach_yb", 32'(m_ph), 32'd4);
    cycle(1, 1, 1, 1, 0, 0);
    repeat (3) cycle(0, 1, 0, 0, 0, 0);

    // Randomized traffic, sparse ticks, pedestrian presses and rare resets.
    sa = 0; sb = 0;
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) sa = ~sa;
      if ($urandom_range(0, 15) == 0) sb = ~sb;
      cycle($urandom_range(0, 499) == 0,
            $urandom_range(0, 3) != 0,
            sa, sb,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 19) == 0);
    end

    @(posedge clk);
    #2;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
